// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return-address-stack controller with branch resolution queue.
// Optional statistics counters are enabled by defining RAS_CTRL_STATS_EN.
module ras_ctrl #(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 16,
  parameter int CNT_W        = 5,
  parameter int RQ_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic             dec_call,
  input  logic             dec_ret,
  input  logic             dec_branch,
  input  logic [WIDTH-1:0] dec_ret_addr,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_mispredict,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic             pred_valid,
  output logic             pred_empty,
  output logic [WIDTH-1:0] pred_addr,
  output logic [CNT_W-1:0] outstanding,
  output logic             res_err,
  output logic [15:0]      stat_calls,
  output logic [15:0]      stat_rets,
  output logic [15:0]      stat_mispred
);

  localparam int PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int QW = PW + 1;

  typedef enum logic [1:0] {S_RUN, S_GAP, S_FLUSH} state_t;

  state_t          state, state_n;
  logic            run_en;
  logic            rq_mem [RQ_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [QW-1:0]   rq_count;
  logic            head_valid, head_mis, active;
  logic            enq, deq, dec_hs;
  logic            pop_q, pop_empty_q;
  logic [WIDTH-1:0] addr_hold;

  // run_en keeps every command quiet during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  assign head_valid = (rq_count != '0);
  assign head_mis   = rq_mem[rd_ptr];
  assign active     = run_en && (state != S_FLUSH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = S_RUN;
    case (state)
      S_RUN:   state_n = ras_close_invalid ? S_FLUSH : (ras_close_valid ? S_GAP : S_RUN);
      S_GAP:   state_n = ras_close_invalid ? S_FLUSH : S_RUN;
      default: state_n = S_RUN;
    endcase
  end

  always_comb begin
    ras_close_valid   = 1'b0;
    ras_close_invalid = 1'b0;
    res_err           = 1'b0;
    if (active && head_valid) begin
      if (outstanding == '0)     res_err           = 1'b1;
      else if (head_mis)         ras_close_invalid = 1'b1;
      else if (state == S_RUN)   ras_close_valid   = 1'b1;
    end
    deq        = ras_close_valid || ras_close_invalid || res_err;
    dec_ready  = active && (outstanding < CNT_W'(MAX_BRANCHES)) && !ras_close_invalid;
    res_ready  = active && ((rq_count != QW'(RQ_DEPTH)) || deq);
    dec_hs     = dec_valid && dec_ready;
    ras_push   = dec_hs && dec_call;
    ras_pop    = dec_hs && dec_ret;
    ras_branch = dec_hs && dec_branch;
    ras_din    = ras_push ? dec_ret_addr : '0;
    enq        = res_valid && res_ready;
  end

  always_ff @(posedge clk) begin
    if (enq) rq_mem[wr_ptr] <= res_mispredict;
  end

  // A mispredict empties the queue, dropping any resolution arriving in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rq_count <= '0;
    end else if (ras_close_invalid) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rq_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      rq_count <= rq_count + QW'(enq) - QW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              outstanding <= '0;
    else if (ras_close_invalid)              outstanding <= '0;
    else if (ras_branch && !ras_close_valid) outstanding <= outstanding + CNT_W'(1);
    else if (!ras_branch && ras_close_valid) outstanding <= outstanding - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_q       <= 1'b0;
      pop_empty_q <= 1'b0;
      addr_hold   <= '0;
    end else begin
      pop_q       <= ras_pop;
      pop_empty_q <= ras_empty;
      if (pred_valid) addr_hold <= ras_dout;
    end
  end

  // The stack presents popped data one cycle after the pop, so the prediction tracks ras_dout.
  assign pred_valid = pop_q && !pop_empty_q;
  assign pred_empty = pop_q && pop_empty_q;
  assign pred_addr  = pred_valid ? ras_dout : addr_hold;

`ifdef RAS_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_calls   <= '0;
      stat_rets    <= '0;
      stat_mispred <= '0;
    end else begin
      if (ras_push && stat_calls != 16'hFFFF)            stat_calls   <= stat_calls + 16'd1;
      if (ras_pop && stat_rets != 16'hFFFF)              stat_rets    <= stat_rets + 16'd1;
      if (ras_close_invalid && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`else
  assign stat_calls   = '0;
  assign stat_rets    = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - self-checking bench for ras_ctrl.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dec_valid = 1'b0, dec_ready;
  logic        dec_call = 1'b0, dec_ret = 1'b0, dec_branch = 1'b0;
  logic [31:0] dec_ret_addr = '0;
  logic        res_valid = 1'b0, res_ready, res_mispredict = 1'b0;
  logic        ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [31:0] ras_din, ras_dout, pred_addr;
  logic        ras_empty, pred_valid, pred_empty, res_err;
  logic [4:0]  outstanding;
  logic [15:0] stat_calls, stat_rets, stat_mispred;

  ras_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_call(dec_call), .dec_ret(dec_ret), .dec_branch(dec_branch),
    .dec_ret_addr(dec_ret_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_mispredict(res_mispredict),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
    .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
    .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
    .pred_valid(pred_valid), .pred_empty(pred_empty), .pred_addr(pred_addr),
    .outstanding(outstanding), .res_err(res_err),
    .stat_calls(stat_calls), .stat_rets(stat_rets), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  // Behavioural return-address stack driven by the controller's commands.
  logic [31:0] stk [64];
  int sp;
  assign ras_empty = (sp == 0);
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp       <= 0;
      ras_dout <= '0;
    end else begin
      if (ras_pop && sp > 0) ras_dout <= stk[sp-1];
      if (ras_push && !ras_pop && sp < 64) begin
        stk[sp] <= ras_din;
        sp      <= sp + 1;
      end else if (ras_pop && !ras_push && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    logic        empty;
    logic [31:0] addr;
  } pred_t;
  pred_t sb[$];

  // Scoreboard: every prediction pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && (pred_valid || pred_empty)) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL pred_unexpected actual=%b%b required=none", pred_valid, pred_empty);
      end else begin
        pred_t e;
        e = sb.pop_front();
        chk("pred_empty", {31'd0, pred_empty}, {31'd0, e.empty});
        chk("pred_valid", {31'd0, pred_valid}, {31'd0, !e.empty});
        if (!e.empty) chk("pred_addr", pred_addr, e.addr);
      end
    end
  end

  typedef struct {
    logic        v, call, ret, br;
    logic [31:0] addr;
    logic        e_push, e_pop, e_br;
    logic [31:0] e_din;
    logic        e_ready;
    logic [1:0]  pred;
    logic [31:0] paddr;
  } vec_t;
  vec_t tbl[7];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    dec_valid = 0; dec_call = 0; dec_ret = 0; dec_branch = 0; dec_ret_addr = '0;
    res_valid = 0; res_mispredict = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_in();
    sb.delete();
    repeat (2) step();
    dec_valid = 1; dec_call = 1; dec_ret_addr = 32'hDEAD;
    #1;
    chk("rst_outstanding", {27'd0, outstanding}, 32'd0);
    chk("rst_pred", {30'd0, pred_valid, pred_empty}, 32'd0);
    chk("rst_pred_addr", pred_addr, 32'd0);
    chk("rst_push", {31'd0, ras_push}, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    chk("rst_stats", {stat_calls, stat_rets | stat_mispred}, 32'd0);
    reset = 1;
    #1;
    chk("first_cycle_push", {31'd0, ras_push}, 32'd0);
    chk("first_cycle_ready", {31'd0, dec_ready}, 32'd0);
    step();
    idle_in();
  endtask

  logic [9:0] cv_mask;

  initial begin
    tbl[0] = '{1,1,0,0,32'h1000, 1,0,0,32'h1000, 1, 2'd0, 32'h0};
    tbl[1] = '{1,0,1,0,32'h0,    0,1,0,32'h0,    1, 2'd1, 32'h1000};
    tbl[2] = '{1,0,1,0,32'h0,    0,1,0,32'h0,    1, 2'd2, 32'h0};
    tbl[3] = '{1,1,0,1,32'h2000, 1,0,1,32'h2000, 1, 2'd0, 32'h0};
    tbl[4] = '{0,1,0,0,32'h5555, 0,0,0,32'h0,    1, 2'd0, 32'h0};
    tbl[5] = '{1,0,1,0,32'h0,    0,1,0,32'h0,    1, 2'd1, 32'h2000};
    tbl[6] = '{1,0,0,1,32'h0,    0,0,1,32'h0,    1, 2'd0, 32'h0};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      dec_valid = tbl[i].v; dec_call = tbl[i].call; dec_ret = tbl[i].ret;
      dec_branch = tbl[i].br; dec_ret_addr = tbl[i].addr;
      #1;
      chk($sformatf("v%0d_push", i), {31'd0, ras_push}, {31'd0, tbl[i].e_push});
      chk($sformatf("v%0d_pop", i), {31'd0, ras_pop}, {31'd0, tbl[i].e_pop});
      chk($sformatf("v%0d_branch", i), {31'd0, ras_branch}, {31'd0, tbl[i].e_br});
      chk($sformatf("v%0d_din", i), ras_din, tbl[i].e_din);
      chk($sformatf("v%0d_ready", i), {31'd0, dec_ready}, {31'd0, tbl[i].e_ready});
      if (tbl[i].pred != 2'd0) sb.push_back('{tbl[i].pred == 2'd2, tbl[i].paddr});
      step();
    end
    idle_in();
    step();
    step();
    chk("pred_addr_hold", pred_addr, 32'h2000);
    chk("outstanding_2", {27'd0, outstanding}, 32'd2);

    // Reset while a pop is pending: no prediction may appear.
    dec_valid = 1; dec_call = 1; dec_ret_addr = 32'h3000;
    step();
    dec_call = 0; dec_ret = 1;
    @(posedge clk);
    #1 reset = 0;
    #1;
    chk("midrst_pred", {30'd0, pred_valid, pred_empty}, 32'd0);
    chk("midrst_addr", pred_addr, 32'd0);
    do_reset();
    repeat (2) step();

    // Sixteen branches fill the budget, one correct resolution frees a slot.
    for (int i = 0; i < 16; i++) begin
      dec_valid = 1; dec_branch = 1;
      step();
    end
    idle_in();
    #1;
    chk("full_outstanding", {27'd0, outstanding}, 32'd16);
    chk("full_dec_ready", {31'd0, dec_ready}, 32'd0);
    res_valid = 1; res_mispredict = 0;
    #1 chk("res_ready", {31'd0, res_ready}, 32'd1);
    step();
    res_valid = 0;
    #1;
    chk("close_valid_16", {31'd0, ras_close_valid}, 32'd1);
    step();
    #1;
    chk("outstanding_15", {27'd0, outstanding}, 32'd15);
    chk("dec_ready_15", {31'd0, dec_ready}, 32'd1);

    // Three back-to-back correct resolutions close on alternate cycles.
    cv_mask = '0;
    for (int i = 0; i < 10; i++) begin
      res_valid = (i < 3); res_mispredict = 0;
      #1 cv_mask[i] = ras_close_valid;
      if (ras_close_invalid) cv_mask = '1;
      step();
    end
    idle_in();
    chk("close_spacing", {22'd0, cv_mask}, 32'b0000101010);
    chk("outstanding_12", {27'd0, outstanding}, 32'd12);

    // Correct, mispredict, correct: close, gap, flush.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dec_valid = 1; dec_branch = 1;
      step();
    end
    idle_in();
    res_valid = 1; res_mispredict = 0;
    step();
    res_mispredict = 1;
    #1 chk("seq_close_valid", {30'd0, ras_close_valid, ras_close_invalid}, 32'b10);
    step();
    res_mispredict = 0;
    #1 chk("seq_close_invalid", {30'd0, ras_close_valid, ras_close_invalid}, 32'b01);
    step();
    res_valid = 0;
    #1;
    chk("flush_ready", {30'd0, dec_ready, res_ready}, 32'b00);
    chk("flush_outstanding", {27'd0, outstanding}, 32'd0);
    chk("flush_cmds", {29'd0, ras_close_valid, ras_close_invalid, res_err}, 32'd0);
    step();
    #1;
    chk("post_flush_ready", {31'd0, dec_ready}, 32'd1);
    chk("post_flush_cmds", {29'd0, ras_close_valid, ras_close_invalid, res_err}, 32'd0);
    step();
    #1 chk("flushed_entry_gone", {29'd0, ras_close_valid, ras_close_invalid, res_err}, 32'd0);

    // Resolution with nothing outstanding.
    res_valid = 1; res_mispredict = 0;
    step();
    res_valid = 0;
    #1;
    chk("res_err_pulse", {31'd0, res_err}, 32'd1);
    chk("res_err_nocmd", {30'd0, ras_close_valid, ras_close_invalid}, 32'd0);
    step();
    #1 chk("res_err_clear", {31'd0, res_err}, 32'd0);

`ifdef RAS_CTRL_STATS_EN
    chk("stat_mispred", {16'd0, stat_mispred}, 32'd1);
    do_reset();
    dec_valid = 1; dec_call = 1; dec_ret_addr = 32'h4;
    for (int i = 0; i < 70000; i++) step();
    idle_in();
    step();
    chk("stat_calls_sat", {16'd0, stat_calls}, 32'h0000FFFF);
    chk("stat_rets_zero", {16'd0, stat_rets}, 32'd0);
`else
    chk("stats_tied_zero", {stat_calls, stat_rets | stat_mispred}, 32'd0);
`endif

    step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
